// File: rtl/stim_traffic_gen_if.sv
// Bus bundle between the stimulus generator/checker and its environment.
interface stim_traffic_gen_if #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned ERR_W  = 8
);
    logic                     start;
    logic                     mode;
    logic [CNT_W-1:0]         burst_len;
    logic [CNT_W-1:0]         drain_len;
    logic                     pause_in;
    logic [NUM_CH-1:0]        next_pop_in;
    logic [NUM_CH*DATA_W-1:0] data_ref;
    logic [NUM_CH*DATA_W-1:0] data_dut;
    logic [DATA_W-1:0]        data_in;
    logic                     push_data_in;
    logic [NUM_CH-1:0]        pop_out;
    logic                     busy;
    logic                     done;
    logic [ERR_W-1:0]         mismatch_cnt;
    logic [NUM_CH-1:0]        err_ch;

    // Generator side
    modport master (
        input  start, mode, burst_len, drain_len, pause_in, next_pop_in, data_ref, data_dut,
        output data_in, push_data_in, pop_out, busy, done, mismatch_cnt, err_ch
    );

    // Environment side
    modport slave (
        output start, mode, burst_len, drain_len, pause_in, next_pop_in, data_ref, data_dut,
        input  data_in, push_data_in, pop_out, busy, done, mismatch_cnt, err_ch
    );
endinterface

// File: rtl/stim_traffic_gen.sv
// Stimulus generator (header / burst / drain) for the main FIFO plus output checker.
module stim_traffic_gen #(
    parameter int unsigned       DATA_W    = 6,
    parameter int unsigned       NUM_CH    = 2,
    parameter int unsigned       CNT_W     = 8,
    parameter int unsigned       ERR_W     = 8,
    parameter logic [DATA_W-1:0] LFSR_SEED = 6'h2D,
    parameter logic [DATA_W-1:0] HDR0      = 6'h3F,
    parameter logic [DATA_W-1:0] HDR1      = 6'h3E
) (
    input  logic                 clk,
    input  logic                 reset,
    stim_traffic_gen_if.master   bus
);

    // Galois tap masks (right-shifting form) for maximal-length sequences.
    function automatic logic [31:0] tap_mask(input int unsigned w);
        case (w)
            2:       return 32'h0003;
            3:       return 32'h0006;
            4:       return 32'h000C;
            5:       return 32'h0014;
            6:       return 32'h0030;
            7:       return 32'h0060;
            8:       return 32'h00B8;
            9:       return 32'h0110;
            10:      return 32'h0240;
            11:      return 32'h0500;
            12:      return 32'h0E08;
            13:      return 32'h1C80;
            14:      return 32'h3802;
            15:      return 32'h6000;
            16:      return 32'hD008;
            default: return 32'h0001 << (w - 1);
        endcase
    endfunction

    localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(tap_mask(DATA_W));
    localparam int unsigned       SUM_W     = ERR_W + $clog2(NUM_CH + 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_STREAM, S_DRAIN, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [CNT_W-1:0]     burst_q, burst_d;
    logic [CNT_W-1:0]     drain_q, drain_d;
    logic [DATA_W-1:0]    gen_q, gen_d, gen_step;
    logic                 push_q, push_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_CH-1:0]    pop_q;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
    logic [NUM_CH-1:0]    err_ch_q, err_ch_d;
    logic [NUM_CH-1:0]    mis_ch;
    logic [SUM_W-1:0]     mis_n;
    logic [SUM_W-1:0]     err_sum;
    logic                 launch;

    // State register and phase counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: cnt holds the cycles remaining after the current one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_HDR0;
            S_HDR0:   state_d = S_HDR1;
            S_HDR1: begin
                if (burst_q != '0) begin
                    state_d = S_STREAM;
                    cnt_d   = burst_q - CNT_W'(1);
                end else if (drain_q != '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = drain_q - CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_STREAM: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (drain_q != '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = drain_q - CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = S_DONE;
            end
            S_DONE:   if (!bus.start) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Per-channel comparison and saturating mismatch sum
    always_comb begin
        mis_ch = '0;
        mis_n  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.data_ref[k*DATA_W +: DATA_W] != bus.data_dut[k*DATA_W +: DATA_W]) begin
                mis_ch[k] = 1'b1;
                mis_n     = mis_n + SUM_W'(1);
            end
        end
        err_sum = SUM_W'(err_cnt_q) + mis_n;
    end

    // Next burst value: increment or Galois LFSR step
    always_comb begin
        if (mode_q) gen_step = gen_q[0] ? ((gen_q >> 1) ^ LFSR_TAPS) : (gen_q >> 1);
        else        gen_step = gen_q + DATA_W'(1);
    end

    // Outputs for the state being entered, config latch and checker update
    always_comb begin
        launch    = (state_q == S_IDLE) && (state_d == S_HDR0);
        push_d    = 1'b0;
        data_d    = '0;
        gen_d     = gen_q;
        mode_d    = mode_q;
        burst_d   = burst_q;
        drain_d   = drain_q;
        err_cnt_d = err_cnt_q;
        err_ch_d  = err_ch_q;
        busy_d    = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                    (state_d == S_STREAM) || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);

        if (launch) begin
            mode_d    = bus.mode;
            burst_d   = bus.burst_len;
            drain_d   = bus.drain_len;
            gen_d     = bus.mode ? LFSR_SEED : '0;
            err_cnt_d = '0;
            err_ch_d  = '0;
        end else if (busy_q) begin
            err_cnt_d = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : ERR_W'(err_sum);
            err_ch_d  = err_ch_q | mis_ch;
        end

        case (state_d)
            S_HDR0: begin
                push_d = 1'b1;
                data_d = HDR0;
            end
            S_HDR1: begin
                push_d = 1'b1;
                data_d = HDR1;
            end
            S_STREAM: begin
                if (!bus.pause_in) begin
                    push_d = 1'b1;
                    data_d = gen_step;
                    gen_d  = gen_step;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q    <= 1'b0;
            burst_q   <= '0;
            drain_q   <= '0;
            gen_q     <= '0;
            push_q    <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pop_q     <= '0;
            err_cnt_q <= '0;
            err_ch_q  <= '0;
        end else begin
            mode_q    <= mode_d;
            burst_q   <= burst_d;
            drain_q   <= drain_d;
            gen_q     <= gen_d;
            push_q    <= push_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pop_q     <= bus.next_pop_in;
            err_cnt_q <= err_cnt_d;
            err_ch_q  <= err_ch_d;
        end
    end

    assign bus.data_in      = data_q;
    assign bus.push_data_in = push_q;
    assign bus.pop_out      = pop_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.mismatch_cnt = err_cnt_q;
    assign bus.err_ch       = err_ch_q;

endmodule

// File: tb/tb_stim_traffic_gen.sv
// Bench for stim_traffic_gen: directed + randomized sequences against a cycle-list model.
module tb_stim_traffic_gen;
    localparam int unsigned DW   = 6;
    localparam int unsigned NC   = 2;
    localparam int unsigned CW   = 8;
    localparam int unsigned EW   = 2;
    localparam int unsigned BW   = NC * DW;
    localparam int          MAXE = (1 << EW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stim_traffic_gen_if #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW), .ERR_W(EW)) bus ();

    stim_traffic_gen #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW), .ERR_W(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          mcnt   = 0;
    logic [NC-1:0] merr = '0;
    logic [NC-1:0] pop_prev = '0;
    int          mi     = 0;
    int          stream_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec LFSR rule for 6 bits: shift right, fold taps x^6+x^5 when a one falls out
    function automatic int lfsr_next(input int s);
        return (s % 2 == 1) ? ((s / 2) ^ 48) : (s / 2);
    endfunction

    // Drive compare data and pops for the next edge; update mismatch model if the edge compares
    task automatic drive_misc(input int mis, input bit counting);
        logic [BW-1:0] r;
        logic [BW-1:0] f;
        r = BW'($urandom);
        f = '0;
        for (int k = 0; k < NC; k++) begin
            if (mis == 1 && $urandom_range(0, 3) == 0) f[k*DW +: DW] = DW'($urandom_range(1, 63));
            if (mis == 2 && counting && mi < 5 && k == 1) f[k*DW +: DW] = 6'h15;
        end
        bus.data_ref    = r;
        bus.data_dut    = r ^ f;
        bus.next_pop_in = NC'($urandom);
        pop_prev        = bus.next_pop_in;
        if (counting) begin
            for (int k = 0; k < NC; k++) begin
                if (f[k*DW +: DW] != '0) begin
                    mcnt    = (mcnt + 1 > MAXE) ? MAXE : mcnt + 1;
                    merr[k] = 1'b1;
                end
            end
            mi++;
        end
    endtask

    task automatic edge_chk(input string tag, input logic ep, input int ed, input logic eb, input logic edn);
        @(posedge clk);
        #1;
        chk({tag, ".push"}, 32'(bus.push_data_in), 32'(ep));
        chk({tag, ".data"}, 32'(bus.data_in),      32'(ed));
        chk({tag, ".busy"}, 32'(bus.busy),         32'(eb));
        chk({tag, ".done"}, 32'(bus.done),         32'(edn));
        chk({tag, ".pop"},  32'(bus.pop_out),      32'(pop_prev));
        chk({tag, ".mcnt"}, 32'(bus.mismatch_cnt), 32'(mcnt));
        chk({tag, ".err"},  32'(bus.err_ch),       32'(merr));
    endtask

    // One full sequence from IDLE back to IDLE, expectations built edge by edge
    task automatic run_seq(input bit m, input int bl, input int dl, input logic [255:0] pmask, input int mis);
        int v;
        int total;
        int js;
        bit p;
        v     = m ? 45 : 0;
        total = 2 + bl + dl;
        mi    = 0;
        stream_q.delete();
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.burst_len = CW'(bl);
        bus.drain_len = CW'(dl);
        bus.pause_in  = 1'($urandom);
        drive_misc(mis, 1'b0);
        mcnt = 0;
        merr = '0;
        edge_chk("hdr0", 1'b1, 63, 1'b1, 1'b0);
        for (int e = 1; e <= total; e++) begin
            bus.start     = 1'($urandom);
            bus.mode      = 1'($urandom);
            bus.burst_len = CW'($urandom);
            bus.drain_len = CW'($urandom);
            bus.pause_in  = 1'($urandom);
            drive_misc(mis, 1'b1);
            js = e - 2;
            if (e == 1) begin
                edge_chk("hdr1", 1'b1, 62, 1'b1, 1'b0);
            end else if (js < bl) begin
                p = pmask[js];
                bus.pause_in = p;
                if (!p) v = m ? lfsr_next(v) : (v + 1) % 64;
                stream_q.push_back(p ? 0 : v);
                edge_chk("stream", !p, p ? 0 : v, 1'b1, 1'b0);
            end else if (e < total) begin
                edge_chk("drain", 1'b0, 0, 1'b1, 1'b0);
            end else begin
                edge_chk("done", 1'b0, 0, 1'b0, 1'b1);
            end
        end
        bus.start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_misc(mis, 1'b0);
            edge_chk("done_hold", 1'b0, 0, 1'b0, 1'b1);
        end
        bus.start = 1'b0;
        drive_misc(mis, 1'b0);
        edge_chk("to_idle", 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int   exp1[8];
        int   exp2[6];
        bit   seen[64];
        int   ndist;
        logic [NC-1:0] pat[4];

        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.mode        = 1'b0;
        bus.burst_len   = '0;
        bus.drain_len   = '0;
        bus.pause_in    = 1'b0;
        bus.next_pop_in = '1;
        bus.data_ref    = '0;
        bus.data_dut    = '1;

        // Reset state
        pop_prev = '0;
        edge_chk("reset", 1'b0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        bus.data_dut = '0;
        drive_misc(1, 1'b0);
        edge_chk("idle0", 1'b0, 0, 1'b0, 1'b0);

        // 1: incrementing burst 8, drain 3
        run_seq(1'b0, 8, 3, '0, 0);
        exp1 = '{1, 2, 3, 4, 5, 6, 7, 8};
        for (int i = 0; i < 8; i++) chk("t1.seq", 32'(stream_q[i]), 32'(exp1[i]));

        // 2: pause in stream cycles 2-3
        run_seq(1'b0, 6, 0, 256'b0110, 0);
        exp2 = '{1, 0, 0, 2, 3, 4};
        for (int i = 0; i < 6; i++) chk("t2.seq", 32'(stream_q[i]), 32'(exp2[i]));

        // 3: wrap in incrementing mode, full LFSR period
        run_seq(1'b0, 70, 1, '0, 1);
        chk("t3.pre_wrap", 32'(stream_q[62]), 32'd63);
        chk("t3.wrap",     32'(stream_q[63]), 32'd0);
        chk("t3.post",     32'(stream_q[64]), 32'd1);
        run_seq(1'b1, 64, 0, '0, 0);
        ndist = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < 63; i++) begin
            if (stream_q[i] != 0 && !seen[stream_q[i]]) ndist++;
            seen[stream_q[i]] = 1'b1;
        end
        chk("t3.lfsr_distinct", 32'(ndist), 32'd63);
        chk("t3.lfsr_repeat",   32'(stream_q[63]), 32'(stream_q[0]));

        // 4: ch1 mismatches for 5 cycles saturate the 2-bit counter
        run_seq(1'b0, 4, 2, '0, 2);
        chk("t4.mcnt_sat", 32'(bus.mismatch_cnt), 32'd3);
        chk("t4.err_ch",   32'(bus.err_ch),       32'b10);
        run_seq(1'b1, 3, 1, '0, 0);

        // 6: pop pattern follows next_pop by one cycle in IDLE
        pat = '{2'b11, 2'b00, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) begin
            drive_misc(1, 1'b0);
            bus.next_pop_in = pat[i];
            pop_prev        = pat[i];
            edge_chk("t6.idle_pop", 1'b0, 0, 1'b0, 1'b0);
        end

        // 5: reset mid-stream
        bus.start     = 1'b1;
        bus.mode      = 1'b1;
        bus.burst_len = CW'(10);
        bus.drain_len = CW'(2);
        bus.pause_in  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_misc(1, 1'b0);
            bus.data_dut = ~bus.data_ref;
            @(posedge clk);
            #1;
        end
        chk("t5.pre_busy", 32'(bus.busy), 32'd1);
        reset           = 1'b0;
        bus.next_pop_in = '1;
        pop_prev        = '0;
        mcnt            = 0;
        merr            = '0;
        edge_chk("t5.reset", 1'b0, 0, 1'b0, 1'b0);
        reset     = 1'b1;
        bus.start = 1'b0;
        drive_misc(1, 1'b0);
        edge_chk("t5.idle", 1'b0, 0, 1'b0, 1'b0);
        run_seq(1'b1, 5, 2, 256'b10010, 1);

        // Boundary lengths and randomized sequences
        run_seq(1'b0, 0, 0, '0, 1);
        run_seq(1'b1, 0, 3, '0, 1);
        run_seq(1'b0, 5, 0, '0, 1);
        for (int n = 0; n < 8; n++) begin
            run_seq(1'($urandom), $urandom_range(0, 20), $urandom_range(0, 5),
                    {8{$urandom}}, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
